// File: rtl/cg_rvarch_instr_encoder_pkg.sv
// Purpose : shared RV32 field definitions for the instruction encoder (opcodes, formats, field bundle).
// Latency : n/a (types, constants and a combinational helper only).
// Backpr. : n/a.
package CG_rvarch_instr_field_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Sticky error code bits
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_IMM    = 2'b10;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } instr_fmt_e;

    // Decoded field bundle; imm is sign-extended and unshifted
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } instr_fields_t;

    function automatic instr_fmt_e opcode_to_fmt(input logic [6:0] opc);
        instr_fmt_e fmt;
        case (opc)
            OPC_LUI, OPC_AUIPC:                     fmt = FMT_U;
            OPC_JAL:                                fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_OP_IMM_32, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                              fmt = FMT_S;
            OPC_BRANCH:                             fmt = FMT_B;
            OPC_OP, OPC_OP_32:                      fmt = FMT_R;
            default:                                fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/cg_rvarch_instr_encoder_pack.sv
// Purpose : packs a decoded field bundle into a 32-bit RV32 word by format; flags bad immediates.
// Latency : combinational.
// Backpr. : none (pure function of inputs).
// Ports   : fields/fmt in; word (encoded instruction), imm_err (immediate fails range/alignment) out.
// Config  : CG_RVARCH_ENC_RANGECHK_EN enables the immediate check; otherwise imm_err is tied low
//           and out-of-range immediate bits are simply truncated by the packing.
import CG_rvarch_instr_field_pkg::*;

module cg_rvarch_instr_pack (
    input  instr_fields_t fields,
    input  instr_fmt_e    fmt,
    output logic [31:0]   word,
    output logic          imm_err
);

    logic [31:0] imm;
    assign imm = fields.imm;

    always_comb begin
        word = 32'h0;
        case (fmt)
            FMT_U: word = {imm[31:12], fields.rd, fields.opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
            FMT_I: word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
            FMT_S: word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
            FMT_B: word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                           imm[4:1], imm[11], fields.opcode};
            FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd,
                           fields.opcode};
            default: word = 32'h0;
        endcase
    end

`ifdef CG_RVARCH_ENC_RANGECHK_EN
    // Signed-fit test: every bit above the field's sign bit must replicate it.
    always_comb begin
        imm_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_err = (imm[31:11] != {21{imm[11]}});
            FMT_B:        imm_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_J:        imm_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_U:        imm_err = (imm[11:0] != 12'h0);
            default:      imm_err = 1'b0;
        endcase
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: rtl/cg_rvarch_instr_encoder.sv
// Purpose : streaming RV32 encoder; packs field bundles and writes words to sequential memory addresses.
// Latency : 1 cycle from accept to o_wr_en/o_wr_addr/o_wr_data (registered).
// Backpr. : o_ready low while a held word waits on i_wr_ready, while full, idle or during i_start.
// Ports   : i_clk/i_rst_n; i_start; i_valid/o_ready + field inputs; o_wr_en/o_wr_addr/o_wr_data/
//           i_wr_ready memory write port; o_count, o_full, o_err_code (sticky), i_err_clr.
// Config  : CG_RVARCH_ENC_RANGECHK_EN (see cg_rvarch_instr_pack) enables immediate range checking.
import CG_rvarch_instr_field_pkg::*;

module cg_rvarch_instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [6:0]        i_opcode,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic [6:0]        i_funct7,
    input  logic [31:0]       i_imm,
    output logic              o_wr_en,
    output logic [31:0]       o_wr_addr,
    output logic [31:0]       o_wr_data,
    input  logic              i_wr_ready,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic [1:0]        o_err_code,
    input  logic              i_err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } state_e;

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_e          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic [ADDR_W:0] issued_q, issued_d;
    logic [ADDR_W:0] count_q, count_d;
    logic [1:0]      err_q, err_d;

    instr_fields_t   fields;
    instr_fmt_e      fmt;
    logic [31:0]     packed_word;
    logic            imm_err;
    logic            accept;
    logic            drop_opc;
    logic            good;
    logic            drain;

    always_comb begin
        fields        = '0;
        fields.opcode = i_opcode;
        fields.rd     = i_rd;
        fields.rs1    = i_rs1;
        fields.rs2    = i_rs2;
        fields.funct3 = i_funct3;
        fields.funct7 = i_funct7;
        fields.imm    = i_imm;
        fmt           = opcode_to_fmt(i_opcode);
    end

    cg_rvarch_instr_pack u_pack (
        .fields  (fields),
        .fmt     (fmt),
        .word    (packed_word),
        .imm_err (imm_err)
    );

    // A new beat may only land in the output register once the held word leaves it.
    assign o_ready  = (state_q == ST_RUN) && !i_start && (!wr_en_q || i_wr_ready) && !o_full;
    assign accept   = i_valid && o_ready;
    assign drop_opc = (fmt == FMT_NONE);
    assign good     = accept && !drop_opc && !imm_err;
    assign drain    = wr_en_q && i_wr_ready;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q && !i_wr_ready;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        issued_d  = issued_q;
        count_d   = drain ? count_q + CNT_ONE : count_q;

        // Clear first so a simultaneous new error still lands.
        err_d = i_err_clr ? 2'b00 : err_q;
        if (accept && drop_opc) begin
            err_d = err_d | ERR_OPCODE;
        end
        if (accept && imm_err) begin
            err_d = err_d | ERR_IMM;
        end

        if (good) begin
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_ADDR + 32'({issued_q, 2'b00});
            wr_data_d = packed_word;
            issued_d  = issued_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN:  state_d = (issued_d == FULL_CNT) ? ST_FULL : ST_RUN;
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
        endcase

        // Restart discards any unwritten word but keeps the sticky error.
        if (i_start) begin
            state_d  = ST_RUN;
            wr_en_d  = 1'b0;
            issued_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'h0;
            wr_data_q <= 32'h0;
            issued_q  <= '0;
            count_q   <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            issued_q  <= issued_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_count    = count_q;
    assign o_full     = (state_q == ST_FULL);
    assign o_err_code = err_q;

endmodule
